// File: rtl/unipolar_rz_receiver.sv
// Unipolar RZ line receiver: measures each high pulse, classifies it as 0/1 against
// a midpoint threshold, assembles MSB-first words and detects the frame-ending low gap.
module unipolar_rz_receiver #(
   parameter int  DATA_WIDTH     = 24,
   parameter real CLOCK_RATE     = 50.0e6,
   parameter real ZERO_HIGH_TIME = 0.4e-6,
   parameter real ONE_HIGH_TIME  = 0.8e-6,
   parameter real RESET_TIME     = 50.0e-6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  line,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  valid,
   output logic                  frame_end,
   output logic                  error
);

   localparam int ZH       = int'(CLOCK_RATE * ZERO_HIGH_TIME);
   localparam int OH       = int'(CLOCK_RATE * ONE_HIGH_TIME);
   localparam int RST      = int'(CLOCK_RATE * RESET_TIME);
   localparam int THRESH   = (ZH + OH) / 2;
   localparam int MIN_HIGH = ZH / 2;
   localparam int MAX_HIGH = 2 * OH;
   localparam int CW       = $clog2(((RST > MAX_HIGH) ? RST : MAX_HIGH) + 2);
   localparam int BW       = $clog2(DATA_WIDTH + 1);

   localparam logic [CW-1:0] RST_C      = CW'(RST);
   localparam logic [CW-1:0] THRESH_C   = CW'(THRESH);
   localparam logic [CW-1:0] MIN_HIGH_C = CW'(MIN_HIGH);
   localparam logic [CW-1:0] MAX_HIGH_C = CW'(MAX_HIGH);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

   localparam logic [1:0] HUNT = 2'd0;
   localparam logic [1:0] LOW  = 2'd1;
   localparam logic [1:0] HIGH = 2'd2;

   logic                  line_m;
   logic                  line_s;
   logic                  line_d;
   logic [1:0]            state;
   logic [CW-1:0]         low_count;
   logic [CW-1:0]         high_count;
   logic [BW-1:0]         bit_count;
   logic [DATA_WIDTH-2:0] shift;

   logic                  rise;
   logic                  fall;
   logic [CW-1:0]         low_inc;
   logic [CW-1:0]         high_inc;
   logic                  rx_bit;
   logic [DATA_WIDTH-1:0] word_next;

   always_comb begin
      rise      = line_s & ~line_d;
      fall      = ~line_s & line_d;
      low_inc   = low_count + 1'b1;
      high_inc  = high_count + 1'b1;
      rx_bit    = (high_count >= THRESH_C);
      // Only DATA_WIDTH-1 bits are stored; the bit being received completes the word.
      word_next = {shift, rx_bit};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         line_m     <= 1'b0;
         line_s     <= 1'b0;
         line_d     <= 1'b0;
         state      <= HUNT;
         low_count  <= '0;
         high_count <= '0;
         bit_count  <= '0;
         shift      <= '0;
         data       <= '0;
         valid      <= 1'b0;
         frame_end  <= 1'b0;
         error      <= 1'b0;
      end else begin
         line_m    <= line;
         line_s    <= line_m;
         line_d    <= line_s;
         valid     <= 1'b0;
         frame_end <= 1'b0;
         error     <= 1'b0;

         case (state)
            HUNT: begin
               if (line_s) begin
                  low_count <= '0;
               end else if (low_inc == RST_C) begin
                  low_count <= RST_C;
                  frame_end <= 1'b1;
                  state     <= LOW;
               end else begin
                  low_count <= low_inc;
               end
            end

            LOW: begin
               if (rise) begin
                  high_count <= CW'(1);
                  state      <= HIGH;
               end else if (low_count != RST_C) begin
                  // Saturating counter: frame_end fires only on the cycle it reaches RST.
                  low_count <= low_inc;
                  if (low_inc == RST_C) begin
                     frame_end <= 1'b1;
                     if (bit_count != '0) begin
                        error     <= 1'b1;
                        bit_count <= '0;
                     end
                  end
               end
            end

            HIGH: begin
               if (fall) begin
                  if (high_count < MIN_HIGH_C) begin
                     error     <= 1'b1;
                     bit_count <= '0;
                     low_count <= '0;
                     state     <= HUNT;
                  end else begin
                     shift     <= word_next[DATA_WIDTH-2:0];
                     low_count <= CW'(1);
                     state     <= LOW;
                     if (bit_count == LAST_BIT) begin
                        data      <= word_next;
                        valid     <= 1'b1;
                        bit_count <= '0;
                     end else begin
                        bit_count <= bit_count + 1'b1;
                     end
                  end
               end else if (line_s) begin
                  if (high_inc > MAX_HIGH_C) begin
                     error     <= 1'b1;
                     bit_count <= '0;
                     low_count <= '0;
                     state     <= HUNT;
                  end else begin
                     high_count <= high_inc;
                  end
               end
            end

            default: begin
               low_count <= '0;
               bit_count <= '0;
               state     <= HUNT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unipolar_rz_receiver.sv
// Directed bench for unipolar_rz_receiver at default parameters
// (ZH=20, OH=40, RST=2500, THRESH=30, MIN_HIGH=10, MAX_HIGH=80).
module tb_unipolar_rz_receiver;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        line  = 1'b0;
   logic [23:0] data;
   logic        valid;
   logic        frame_end;
   logic        error;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          valid_count = 0;
   int          fe_count = 0;
   int          err_count = 0;
   int          fe_err_count = 0;
   int          valid_cyc = 0;
   int          err_cyc = 0;
   int          last_fall = 0;
   int          t0 = 0;
   logic [31:0] words [$];
   logic [31:0] got;

   unipolar_rz_receiver dut (
      .clock     (clock),
      .reset     (reset),
      .line      (line),
      .data      (data),
      .valid     (valid),
      .frame_end (frame_end),
      .error     (error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (valid) begin
         valid_count++;
         valid_cyc = cyc;
         words.push_back({8'h00, data});
      end
      if (frame_end) fe_count++;
      if (error) begin
         err_count++;
         err_cyc = cyc;
      end
      if (frame_end && error) fe_err_count++;
   end

   task automatic check_value(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_vec++;
      if (got_v !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
      end
   endtask

   task automatic clear_counts();
      valid_count  = 0;
      fe_count     = 0;
      err_count    = 0;
      fe_err_count = 0;
      words.delete();
   endtask

   // Drive a level for n raw cycles; all edges land 1 time unit after a posedge.
   task automatic hold(input logic v, input int n);
      line = v;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      hold(1'b1, b ? 40 : 20);
      last_fall = cyc;
      hold(1'b0, b ? 35 : 55);
   endtask

   task automatic send_bits(input logic [31:0] value, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(value[i]);
   endtask

   function automatic logic [31:0] word_at(input int idx);
      if (idx < words.size()) return words[idx];
      return 32'hDEAD_BEEF;
   endfunction

   initial begin
      repeat (4) @(posedge clock);
      #1;
      check_value("reset_data", {8'h00, data}, 32'h0);
      check_value("reset_valid", {31'b0, valid}, 32'h0);
      check_value("reset_frame_end", {31'b0, frame_end}, 32'h0);
      check_value("reset_error", {31'b0, error}, 32'h0);
      reset = 1'b0;

      // Initial gap: frame_end exactly at low count 2500
      hold(1'b0, 2498);
      check_value("gap_early_fe", fe_count, 0);
      hold(1'b0, 102);
      check_value("gap_fe", fe_count, 1);
      check_value("gap_valid", valid_count, 0);
      check_value("gap_error", err_count, 0);

      // Single word with latency check
      clear_counts();
      send_bits(32'hA5C30F, 24);
      check_value("w1_valid_cnt", valid_count, 1);
      check_value("w1_data", word_at(0), 32'hA5C30F);
      check_value("w1_latency", valid_cyc - last_fall, 3);
      hold(1'b0, 2600);
      check_value("w1_fe", fe_count, 1);
      check_value("w1_err", err_count, 0);

      // Back-to-back words
      clear_counts();
      send_bits(32'h000001, 24);
      send_bits(32'hFFFFFE, 24);
      hold(1'b0, 2600);
      check_value("b2b_valid_cnt", valid_count, 2);
      check_value("b2b_word0", word_at(0), 32'h000001);
      check_value("b2b_word1", word_at(1), 32'hFFFFFE);
      check_value("b2b_fe", fe_count, 1);
      check_value("b2b_err", err_count, 0);

      // Truncated word
      clear_counts();
      send_bits(32'h2AB, 10);
      hold(1'b0, 2600);
      check_value("trunc_fe_err", fe_err_count, 1);
      check_value("trunc_err", err_count, 1);
      check_value("trunc_valid", valid_count, 0);
      check_value("trunc_data_held", {8'h00, data}, 32'hFFFFFE);
      send_bits(32'h123456, 24);
      hold(1'b0, 2600);
      check_value("trunc_next_valid", valid_count, 1);
      check_value("trunc_next_data", word_at(0), 32'h123456);

      // Glitch mid-word, then bits ignored until a full gap
      clear_counts();
      send_bits(32'h15, 5);
      hold(1'b1, 5);
      hold(1'b0, 50);
      check_value("glitch_err", err_count, 1);
      send_bits(32'hABCDEF, 24);
      check_value("glitch_ignored", valid_count, 0);
      check_value("glitch_err_once", err_count, 1);
      hold(1'b0, 2600);
      check_value("glitch_fe", fe_count, 1);
      send_bits(32'h5A5A5A, 24);
      check_value("glitch_next_data", word_at(0), 32'h5A5A5A);
      hold(1'b0, 2600);

      // Stuck high: error at the 81st high sample
      clear_counts();
      t0 = cyc;
      hold(1'b1, 100);
      check_value("stuck_err", err_count, 1);
      check_value("stuck_err_time", err_cyc - t0, 83);
      hold(1'b0, 2600);
      check_value("stuck_fe", fe_count, 1);
      check_value("stuck_err_total", err_count, 1);

      // Reset mid-word
      clear_counts();
      send_bits(32'hFED, 12);
      reset = 1'b1;
      hold(1'b0, 3);
      check_value("rst_mid_data", {8'h00, data}, 32'h0);
      reset = 1'b0;
      hold(1'b0, 2600);
      check_value("rst_mid_valid", valid_count, 0);
      check_value("rst_mid_fe", fe_count, 1);
      send_bits(32'hC0FFEE, 24);
      hold(1'b0, 100);
      check_value("rst_next_data", word_at(0), 32'hC0FFEE);
      check_value("rst_err", err_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/unipolar_rz_receiver.md
Name: unipolar_rz_receiver

Overview:
- Decoder for the unipolar return-to-zero serial line driven by the team's RZ transmitter; used for loopback checks and for receiving from daisy-chained RZ devices (WS2812-class).
- Synchronises the raw line and measures each high pulse in clock cycles. Classifies each pulse as 0 or 1 against a midpoint threshold.
- Assembles bits MSB-first into DATA_WIDTH-bit words. Detects the long low reset gap that ends a frame.

Parameters:
- DATA_WIDTH, 24, bits per word; MSB is received first.
- CLOCK_RATE, 50.0e6, clock frequency in Hz (real).
- ZERO_HIGH_TIME, 0.4e-6, nominal high time of a 0 bit in seconds (real).
- ONE_HIGH_TIME, 0.8e-6, nominal high time of a 1 bit in seconds (real).
- RESET_TIME, 50.0e-6, minimum low time that ends a frame in seconds (real).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- line  input  1  raw RZ line; asynchronous to clock.
- data  output  DATA_WIDTH  last completed word; held until the next word completes.
- valid  output  1  one-cycle pulse; data is new this cycle.
- frame_end  output  1  one-cycle pulse; a reset gap was detected.
- error  output  1  one-cycle pulse; pulse-width violation or truncated word.

Behaviour:
- Derived constants, all integer cycles rounded via int'(CLOCK_RATE*t):
  - ZH = zero high; OH = one high; RST = reset.
  - THRESH = (ZH+OH)/2.
  - MIN_HIGH = ZH/2.
  - MAX_HIGH = 2*OH.
  - Counter width = $clog2(max(RST, MAX_HIGH)+2).
- Input path: 2-flop synchroniser to line_s, plus one delay flop line_d.
  - rise = line_s & !line_d; fall = !line_s & line_d.
- Outputs are registered. On reset: data=0, valid=0, frame_end=0, error=0, bit count=0, state=HUNT, counters=0.
- State HUNT (not yet framed):
  - Count consecutive low cycles; any high sample clears the count.
  - When the count reaches RST: pulse frame_end, go to LOW.
- State LOW:
  - Low counter increments, saturating at RST.
  - When it reaches exactly RST: pulse frame_end once. If bit count != 0, also pulse error and discard the partial word (bit count := 0).
  - On rise: go to HIGH with high counter := 1.
- State HIGH:
  - High counter increments each cycle line_s=1.
  - If the counter exceeds MAX_HIGH (stuck high): pulse error, clear the partial word, go to HUNT.
  - On fall with width h:
    - If h < MIN_HIGH: pulse error, clear the partial word, go to HUNT (glitch).
    - Otherwise bit = (h >= THRESH). Shift it into the LSB of the shift register; increment bit count; low counter := 1; go to LOW.
- Word completion: when the received bit makes bit count == DATA_WIDTH:
  - On the same edge: data := completed shift value, valid := 1, bit count := 0.
  - valid is seen the cycle after the 3rd posedge following the raw falling edge of the last bit.
  - Back-to-back words need no gap; the next bit continues into a new word.
- Low time between bits shorter than RST is accepted regardless of length; there is no low-time classification.
- error, valid and frame_end are never asserted in the same cycle by construction, except frame_end+error on a truncated frame.
- reset asserted mid-word: all state is discarded immediately and no pulse is emitted. After release, the block must see a full RST low gap (HUNT) before accepting bits.

Test Plan (defaults: ZH=20, OH=40, RST=2500, THRESH=30):
- Hold line low 2500 cycles after reset -> exactly one frame_end pulse; no valid, no error.
- Frame, then 24 bits of 0xA5C30F (1=40 high/35 low, 0=20 high/55 low) -> one valid with data=0xA5C30F; the next gap gives frame_end with error=0.
- Two words 0x000001 and 0xFFFFFE back-to-back, then gap -> two valid pulses in order with those values, then a single frame_end.
- 10 bits, then a 2500-cycle low gap -> frame_end and error in the same cycle; data unchanged; the next 24-bit word decodes correctly.
- 5-cycle glitch high pulse mid-word -> error pulse, return to HUNT; bits are ignored until a 2500-cycle low gap.
- Line held high 100 cycles -> error at high count 81. Also: reset asserted at bit 12 -> no valid; the next word after a gap decodes correctly.
